// File: rtl/decimacao_parametrizada_pkg.sv
// Shared types for the power-of-two raster decimator.
// State encodings, mode codes and accumulator sizing.
package decimacao_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PROC,
    S_DRAIN
  } estado_t;

  localparam logic MODO_AMOSTRAGEM = 1'b0;
  localparam logic MODO_MEDIA      = 1'b1;

  // Holds the sum of a full (2^k)x(2^k) block without wrap.
  function automatic int acc_w(input int pw, input int lmf);
    return pw + 2 * lmf;
  endfunction

endpackage

// File: rtl/decimacao_parametrizada_if.sv
// Valid/ready pixel stream used on both sides of the decimator.
// master drives data/valid, slave drives ready.
interface decimacao_parametrizada_if #(
  parameter int W = 8
);

  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );

endinterface

// File: rtl/decimacao_parametrizada_acc_linha.sv
// Per-column partial-sum line buffer for block averaging.
// Combinational read, one synchronous write per cycle.
module decim_acc_linha #(
  parameter int W     = 12,
  parameter int DEPTH = 640,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/decimacao_parametrizada.sv
// Raster-stream decimator by 2^k: top-left sampling or
// rounded NxN block mean, with valid/ready on both sides.
module decimacao_parametrizada
  import decimacao_pkg::*;
#(
  parameter int PIXEL_W        = 8,
  parameter int DIM_W          = 10,
  parameter int MAX_LARGURA    = 640,
  parameter int LOG2_MAX_FATOR = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic [DIM_W-1:0] largura_in,
  input  logic [DIM_W-1:0] altura_in,
  input  logic [$clog2(LOG2_MAX_FATOR+1)-1:0] log2_fator,
  input  logic modo,
  decimacao_parametrizada_if.slave  pix_in,
  decimacao_parametrizada_if.master pix_out,
  output logic [DIM_W-1:0] largura_out,
  output logic [DIM_W-1:0] altura_out,
  output logic processing_done,
  output logic config_error
);

  localparam int ACC_W = acc_w(PIXEL_W, LOG2_MAX_FATOR);
  localparam int AW    = $clog2(MAX_LARGURA);
  localparam int KW    = $clog2(LOG2_MAX_FATOR + 1);

  estado_t estado, estado_nx;

  logic [DIM_W-1:0] larg, alt;
  logic [DIM_W-1:0] x, y;
  logic [DIM_W-1:0] msk, lim_x, lim_y;
  logic [KW-1:0]    k;
  logic             modo_r;

  logic cfg_ok, aceita_cfg;
  logic ready_in, xfer, ultimo;
  logic in_range, bloco_ini, bloco_fim;
  logic emite, drain_ok;

  logic [ACC_W-1:0] acc_rd, acc_wd;
  logic             acc_we;
  logic [AW-1:0]    acc_addr;
  logic [ACC_W:0]   soma, rnd;
  logic [PIXEL_W-1:0] media, dado_emit;

  logic               pov;
  logic [PIXEL_W-1:0] pdata;

  assign cfg_ok = (largura_in != '0)
               && (altura_in != '0)
               && (32'(largura_in) <= MAX_LARGURA)
               && (32'(log2_fator) <= LOG2_MAX_FATOR);

  assign aceita_cfg = (estado == S_IDLE)
                   && start && cfg_ok;

  assign ready_in = (estado == S_PROC)
                 && (!pov || pix_out.ready);
  assign xfer     = pix_in.valid && ready_in;

  assign ultimo = (x == larg - DIM_W'(1))
               && (y == alt - DIM_W'(1));

  assign msk   = (DIM_W'(1) << k) - DIM_W'(1);
  assign lim_x = largura_out << k;
  assign lim_y = altura_out << k;

  // Trailing partial blocks fall outside lim_x/lim_y.
  assign in_range  = (x < lim_x) && (y < lim_y);
  assign bloco_ini = ((x & msk) == '0)
                  && ((y & msk) == '0);
  assign bloco_fim = ((x & msk) == msk)
                  && ((y & msk) == msk);

  assign acc_addr = AW'(x >> k);

  assign acc_wd = bloco_ini
                ? ACC_W'(pix_in.data)
                : acc_rd + ACC_W'(pix_in.data);

  assign rnd = (k == '0)
             ? '0
             : (ACC_W + 1)'(1) << (2 * k - 1);

  assign soma = (bloco_ini ? '0 : {1'b0, acc_rd})
              + (ACC_W + 1)'(pix_in.data)
              + rnd;

  assign media = PIXEL_W'(soma >> (2 * k));

  assign emite = xfer && in_range
              && ((modo_r == MODO_MEDIA)
                  ? bloco_fim
                  : bloco_ini);

  assign dado_emit = (modo_r == MODO_MEDIA)
                   ? media
                   : pix_in.data;

  // The closing pixel of a block goes out, never back in.
  assign acc_we = xfer && in_range
               && (modo_r == MODO_MEDIA)
               && !bloco_fim;

  assign drain_ok = !pov || pix_out.ready;

  decim_acc_linha #(
    .W     (ACC_W),
    .DEPTH (MAX_LARGURA),
    .AW    (AW)
  ) u_acc (
    .clk   (clk),
    .we    (acc_we),
    .addr  (acc_addr),
    .wdata (acc_wd),
    .rdata (acc_rd)
  );

  always_comb begin
    estado_nx = estado;
    unique case (estado)
      S_IDLE: begin
        if (aceita_cfg) estado_nx = S_PROC;
      end
      S_PROC: begin
        if (xfer && ultimo) estado_nx = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_ok) estado_nx = S_IDLE;
      end
      default: estado_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado          <= S_IDLE;
      larg            <= '0;
      alt             <= '0;
      k               <= '0;
      modo_r          <= MODO_AMOSTRAGEM;
      x               <= '0;
      y               <= '0;
      largura_out     <= '0;
      altura_out      <= '0;
      pov             <= 1'b0;
      pdata           <= '0;
      processing_done <= 1'b0;
      config_error    <= 1'b0;
    end else begin
      estado <= estado_nx;

      processing_done <= (estado == S_DRAIN)
                      && drain_ok;
      config_error    <= (estado == S_IDLE)
                      && start && !cfg_ok;

      if (aceita_cfg) begin
        larg        <= largura_in;
        alt         <= altura_in;
        k           <= log2_fator;
        modo_r      <= modo;
        largura_out <= largura_in >> log2_fator;
        altura_out  <= altura_in >> log2_fator;
        x           <= '0;
        y           <= '0;
      end

      if (xfer) begin
        if (x == larg - DIM_W'(1)) begin
          x <= '0;
          y <= y + DIM_W'(1);
        end else begin
          x <= x + DIM_W'(1);
        end
      end

      // A new emission reloads even while draining.
      if (emite) begin
        pov   <= 1'b1;
        pdata <= dado_emit;
      end else if (pix_out.ready) begin
        pov <= 1'b0;
      end
    end
  end

  assign pix_in.ready  = ready_in;
  assign pix_out.valid = pov;
  assign pix_out.data  = pdata;

endmodule

// File: doc/decimacao_parametrizada.md
Name: decimacao_parametrizada

Overview:
- Parametrised successor of the fixed 2x nearest-neighbour zoom-out block in the image-scaling path.
- Reduces a raster-order pixel stream by a run-time power-of-two factor: 1x, 2x, 4x, up to 2^LOG2_MAX_FATOR.
- Two modes: sampling (top-left pixel of each block) and block averaging (rounded mean of each NxN block).
- Adds valid/ready backpressure on both sides, a configuration error flag and registered output dimensions.

Parameters:
PIXEL_W, 8, pixel width in bits
DIM_W, 10, width of dimension/counter fields
MAX_LARGURA, 640, maximum input width; sizes the accumulator line buffer
LOG2_MAX_FATOR, 2, maximum log2 of the decimation factor (factor up to 4)

Ports:
clk  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; samples the configuration in S_IDLE
largura_in  in  DIM_W  input width in pixels
altura_in  in  DIM_W  input height in pixels
log2_fator  in  clog2(LOG2_MAX_FATOR+1)  factor = 2^log2_fator
modo  in  1  0 = sampling, 1 = block average
pixel_in  in  PIXEL_W  input pixel, raster order
pixel_in_valid  in  1  input pixel present
pixel_in_ready  out  1  block accepts pixel_in this cycle
pixel_out  out  PIXEL_W  output pixel
pixel_out_valid  out  1  pixel_out present
pixel_out_ready  in  1  downstream accepts pixel_out
largura_out  out  DIM_W  floor(largura/factor), registered at start
altura_out  out  DIM_W  floor(altura/factor), registered at start
processing_done  out  1  one-cycle pulse at frame end
config_error  out  1  one-cycle pulse when start is rejected

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Reset values (all outputs and state): pixel_out=0, pixel_out_valid=0, processing_done=0, config_error=0, largura_out=0, altura_out=0, counters=0, state=S_IDLE. The accumulator array is not cleared.
- Reset mid-frame: abandons the frame without a done pulse and drops any pending output.
- States:
  - S_IDLE: on start, check the configuration.
    - Reject if largura_in==0, altura_in==0, largura_in>MAX_LARGURA, or log2_fator>LOG2_MAX_FATOR. On reject: config_error=1 for one cycle, stay in S_IDLE.
    - Otherwise: latch the configuration, clear x/y, go to S_PROC.
  - S_PROC: consume pixels. After the last input pixel is accepted, go to S_DRAIN.
  - S_DRAIN: wait until pixel_out_valid==0, or it falls on handshake. Then pulse processing_done the next cycle and return to S_IDLE.
- start outside S_IDLE is ignored.
- Input handshake: pixel_in_ready = (state==S_PROC) && (!pixel_out_valid || pixel_out_ready). A transfer happens when valid && ready.
- Coordinates: each transfer advances x; at x==largura-1, x wraps to 0 and y increments. The transfer at (largura-1, altura-1) is the last.
- Let k=log2_fator and m=2^k-1. Pixels with x>=largura_out<<k or y>=altura_out<<k are consumed and discarded in both modes, i.e. trailing partial blocks are truncated.
- Sampling mode: emit pixel_in when (x&m)==0 and (y&m)==0.
- Average mode: acc[x>>k] has width PIXEL_W+2*LOG2_MAX_FATOR.
  - If (x&m)==0 and (y&m)==0: acc = pixel.
  - Otherwise: acc += pixel.
  - When (x&m)==m and (y&m)==m: emit (acc+pixel+round)>>(2k) and do not store, where round=2^(2k-1) for k>0 and 0 for k==0.
- k==0 in either mode is a pass-through.
- Output register:
  - pixel_out_valid is set the cycle after an emitting transfer, latency 1.
  - It holds stable until pixel_out_ready; it clears on handshake unless a new emission arrives in the same cycle, in which case it reloads.
  - Emission and drain in the same cycle are legal and produce no bubble.
- Output count per frame is exactly largura_out*altura_out.
- pixel_in_valid low simply stalls; counters do not advance.

Decomposition:
- Package decimacao_pkg: state encodings S_IDLE/S_PROC/S_DRAIN, MODO_AMOSTRAGEM=0, MODO_MEDIA=1, accumulator-width function.
- Sub-module decim_acc_linha: MAX_LARGURA>>0-deep register array, combinational read and synchronous write, one write per cycle.
- Addressing and counters remain in the top level.

Test Plan:
- Sampling, 8x4 image, pixel=y*8+x, k=1, ready always 1 -> outputs 0,2,4,6,16,18,20,22; largura_out=4, altura_out=2; done pulse once.
- Average, 4x4, k=1, pixels 0..15 -> outputs 3,5,11,13, each equal to (sum+2)>>2 e.g. (0+1+4+5+2)>>2=3.
- Average, 4x4, k=2, all pixels 255 -> single output 255, no overflow; 5x5 image with k=1 -> 4 outputs, column 4 and row 4 discarded.
- Backpressure: pixel_out_ready toggling 1010..., k=0, 3x2 -> all 6 pixels delivered in order, pixel_out stable while stalled, pixel_in_ready low whenever output is full and not draining.
- start with log2_fator=3, or largura_in=0, or largura_in=641 -> config_error pulse, state stays idle, pixel_in_ready=0.
- reset asserted after 5 pixels of an 8x8 frame -> all outputs return to reset values next cycle; a new start runs a full frame with correct output.
